// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/pause/lap/clear control with prescaled count enable
module stopwatch_ctrl #(
  parameter int DIV = 500000
) (
  input  logic CLK,
  input  logic R,
  input  logic SS,
  input  logic LC,
  output logic CE,
  output logic CLR,
  output logic DISP_LD,
  output logic RUN_LED,
  output logic LAP_LED
);
  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  state_t state_q, state_d;
  logic [W-1:0] presc_q, presc_d;
  logic ss_prev_q, ss_prev_d, lc_prev_q, lc_prev_d;
  logic ss_edge, lc_edge, counting;
  // state, prescaler and button history; prev regs reset high so a held button is not an edge
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      ss_prev_q <= 1'b1;
      lc_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ss_prev_q <= ss_prev_d;
      lc_prev_q <= lc_prev_d;
    end
  end
  // next state (start/stop wins over lap/clear), prescaler update and state-decoded outputs
  always_comb begin
    ss_edge   = SS & ~ss_prev_q;
    lc_edge   = LC & ~lc_prev_q;
    counting  = (state_q == RUN) || (state_q == LAP);
    ss_prev_d = SS;
    lc_prev_d = LC;
    state_d   = ss_edge ? (counting ? STOP : RUN)
              : lc_edge ? (state_q == RUN ? LAP : state_q == LAP ? RUN : IDLE)
              : state_q;
    presc_d   = counting ? (presc_q == LAST ? '0 : presc_q + 1'b1)
              : state_q == STOP ? presc_q : '0;
    CE        = counting && (presc_q == LAST);
    CLR       = state_q == IDLE;
    DISP_LD   = state_q != LAP;
    RUN_LED   = counting;
    LAP_LED   = state_q == LAP;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch datapath built from cascaded mod-10 BCD counter stages. Converts two pushbutton levels (start/stop, lap/clear) into a run/pause/lap/clear sequence and generates the counter chain's count-enable pulse from an internal prescaler, the chain's synchronous clear, and the display-register load enable. Sits between the debounced button synchronizers and the counter chain/display latch; it contains no BCD counters itself.

## Interface
- DIV, default 500000: prescaler divide ratio; one CE pulse every DIV clocks while counting (100 Hz from 50 MHz). Legal range DIV >= 2.
- CLK  input  1  system clock; all state changes on rising edge.
- R  input  1  reset, asynchronous, active-high.
- SS  input  1  start/stop button level, already synchronized/debounced; action on rising edge.
- LC  input  1  lap/clear button level, already synchronized/debounced; action on rising edge.
- CE  output  1  count enable to least-significant counter stage; one-cycle pulse.
- CLR  output  1  synchronous clear to counter chain; level.
- DISP_LD  output  1  display register load enable; 0 freezes displayed value.
- RUN_LED  output  1  high while counting (RUN or LAP).
- LAP_LED  output  1  high in LAP.

## Operation
- Edge detect: ss_prev/lc_prev registered each clock; ss_edge = SS & ~ss_prev, lc_edge = LC & ~lc_prev. Both prev registers reset to 1, so a button held through reset produces no edge.
- States: IDLE, RUN, LAP, STOP (2-bit encoding, implementer's choice).
- Transitions (evaluated each rising edge):
  - IDLE: ss_edge -> RUN; lc_edge -> IDLE.
  - RUN: ss_edge -> STOP; lc_edge -> LAP.
  - LAP: ss_edge -> STOP; lc_edge -> RUN.
  - STOP: ss_edge -> RUN; lc_edge -> IDLE.
  - ss_edge and lc_edge in same cycle: ss_edge transition taken, lc_edge discarded.
- Prescaler presc, width clog2(DIV):
  - RUN or LAP: presc <= (presc == DIV-1) ? 0 : presc+1.
  - STOP: hold (resume continues partial tick).
  - IDLE: presc <= 0.
- Outputs, decoded from current state/presc (no dependence on SS/LC):
  - CE = (state is RUN or LAP) & (presc == DIV-1).
  - CLR = (state == IDLE).
  - DISP_LD = (state != LAP).
  - RUN_LED = (state is RUN or LAP); LAP_LED = (state == LAP).
- Entering STOP from LAP unfreezes display (DISP_LD=1) so the true stopped time is shown.

## Timing
- Reset values: state IDLE, presc 0, ss_prev/lc_prev 1; CE 0, CLR 1, DISP_LD 1, RUN_LED 0, LAP_LED 0. Reset mid-count returns to these immediately (asynchronous), regardless of state or presc.
- Button latency: SS/LC high before rising edge k with prev=0 -> state changes at edge k; outputs reflect new state after edge k.
- First CE after IDLE->RUN at edge k: CE high for the cycle between edges k+DIV-1 and k+DIV; counters advance at edge k+DIV. Thereafter one CE every DIV cycles.
- CE never high for two consecutive cycles (DIV >= 2). CE never high in IDLE or STOP.
- RUN->STOP at an edge where presc == DIV-1: the CE in that cycle is counted (counter advances at that edge); presc holds the wrapped value 0 in STOP.
- STOP->RUN: next CE after DIV-1-presc_held cycles plus one, i.e. total run time across the pause equals uninterrupted run time.
- RUN<->LAP does not disturb presc or CE cadence.
- CLR asserted for every cycle in IDLE, including the first cycle after reset; deasserts after the edge that enters RUN.

## Test plan
- Reset/hold: DIV=4, assert R with SS=1 held, release R, keep SS high 10 cycles -> state stays IDLE, CLR=1, CE never high, DISP_LD=1.
- Run cadence: DIV=4, SS pulse (edge at k) -> RUN_LED=1 after k, CE high exactly in cycles ending at k+4, k+8, k+12; CLR=0 after k.
- Pause/resume: DIV=4, run until presc=2, SS pulse -> STOP, hold 7 cycles (presc stays 2, no CE), SS pulse -> next CE after 2 cycles (presc 3), then every 4.
- Lap: in RUN, LC pulse -> LAP_LED=1, DISP_LD=0, CE cadence unchanged; second LC pulse -> RUN, DISP_LD=1; LC then SS in LAP -> STOP with DISP_LD=1.
- Clear: from STOP, LC pulse -> IDLE, CLR=1, presc=0; from RUN, LC goes to LAP not IDLE.
- Simultaneous/async: SS and LC rise same cycle in RUN -> STOP (not LAP); assert R mid-RUN with presc=3 -> all outputs reset values immediately, before next CLK edge.
